// File: rtl/apb_master_bridge_if.sv
// Bus bundle between the CPU data port, the APB bridge and the APB slaves.
// Handshake: transfer is a request strobe sampled only while the bridge is idle.
// The CPU holds or reissues it until it sees ready, a one-cycle completion pulse
// that err qualifies. On the APB side PSEL/PENABLE run SETUP then ACCESS, and the
// selected slave ends ACCESS with PREADY.
interface apb_master_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    // CPU side
    logic                     transfer;
    logic [31:0]              addr;
    logic                     write;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     ready;
    logic                     err;
    // APB side
    logic [31:0]              PADDR;
    logic                     PWRITE;
    logic [31:0]              PWDATA;
    logic                     PENABLE;
    logic [NUM_SLAVES-1:0]    PSEL;
    logic [32*NUM_SLAVES-1:0] PRDATA_all;
    logic [NUM_SLAVES-1:0]    PREADY_all;
    // FSM state for observation
    logic [1:0]               dbg_state;

    modport master (
        input  transfer, addr, write, wdata, PRDATA_all, PREADY_all,
        output rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL, dbg_state
    );

    modport slave (
        output transfer, addr, write, wdata, PRDATA_all, PREADY_all,
        input  rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL, dbg_state
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: latches one CPU request, decodes it to a single PSEL line,
// runs SETUP/ACCESS with a bounded wait and returns a registered ready/err pulse.
module apb_master_bridge #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
    parameter int          SPAN_BITS      = 12,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input logic                 PCLK,
    input logic                 PRESET,
    apb_master_bridge_if.master bus
);
    localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TAGS = SPAN_BITS + IDXW;
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
    // Value the count holds on the last permitted ACCESS edge.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ERR    = 2'd1,
        S_SETUP  = 2'd2,
        S_ACCESS = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [IDXW-1:0]       req_idx, sel_idx;
    logic                  req_hit;
    logic                  pready_sel;
    logic [31:0]           prdata_sel;
    logic                  cnt_done;
    logic [CW-1:0]         cnt;
    logic [31:0]           paddr_q, pwdata_q, rdata_q;
    logic                  pwrite_q, ready_q, err_q;
    logic [NUM_SLAVES-1:0] psel_c;
    logic                  penable_c;

    // Address decode of the incoming request: region tag match plus slave index range.
    always_comb begin
        req_idx = bus.addr[SPAN_BITS +: IDXW];
        req_hit = ((bus.addr >> TAGS) == (ADDR_BASE >> TAGS)) &&
                  ({1'b0, req_idx} < (IDXW + 1)'(NUM_SLAVES));
    end

    // Pick the latched slave's PREADY/PRDATA; all other slaves are ignored.
    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_idx == k[IDXW-1:0]) begin
                pready_sel = bus.PREADY_all[k];
                prdata_sel = bus.PRDATA_all[32*k +: 32];
            end
        end
        cnt_done = (cnt == CNT_LAST);
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: success on PREADY takes priority over the expiring count.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.transfer) state_nxt = req_hit ? S_SETUP : S_ERR;
            S_ERR:    state_nxt = S_IDLE;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (pready_sel || cnt_done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // APB strobes decoded straight from state so reset clears them without a clock.
    always_comb begin
        penable_c = (state == S_ACCESS);
        psel_c    = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            psel_c[k] = ((state == S_SETUP) || (state == S_ACCESS)) && (sel_idx == k[IDXW-1:0]);
        end
    end

    // Request latch, ACCESS wait counter and the registered completion pulse.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            sel_idx  <= '0;
            cnt      <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.transfer) begin
                        paddr_q  <= bus.addr;
                        pwrite_q <= bus.write;
                        pwdata_q <= bus.wdata;
                        sel_idx  <= req_idx;
                        cnt      <= '0;
                    end
                end
                S_ERR: begin
                    ready_q <= 1'b1;
                    err_q   <= 1'b1;
                end
                S_ACCESS: begin
                    if (pready_sel) begin
                        ready_q <= 1'b1;
                        if (!pwrite_q) rdata_q <= prdata_sel;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt_done) begin
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSEL      = psel_c;
    assign bus.PENABLE   = penable_c;
    assign bus.rdata     = rdata_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: three slaves with programmable wait states,
// a short timeout, directed scenarios then randomized transfers.
module tb_apb_master_bridge;
    localparam int          NS   = 3;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          WIN  = 4096;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b0;

    apb_master_bridge_if #(.NUM_SLAVES(NS)) bus ();

    apb_master_bridge #(
        .NUM_SLAVES    (NS),
        .ADDR_BASE     (BASE),
        .SPAN_BITS     (12),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 PCLK = ~PCLK;

    // ---------------- slave models ----------------
    // mode 0: registered PREADY after slv_wait extra cycles; 1: PREADY stuck low;
    // 2: PREADY stuck high with all-ones PRDATA.
    logic [31:0]   slv_mem [NS][16];
    int            slv_mode[NS];
    int            slv_wait[NS];
    int            slv_cnt [NS];
    logic [NS-1:0] slv_ready;

    // Slave PREADY generation and write capture.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            slv_ready <= '0;
            for (int k = 0; k < NS; k++) slv_cnt[k] <= 0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (slv_mode[k] == 2) begin
                    slv_ready[k] <= 1'b1;
                end else if (slv_mode[k] == 1) begin
                    slv_ready[k] <= 1'b0;
                end else if (bus.PSEL[k] && bus.PENABLE) begin
                    if (slv_ready[k]) begin
                        slv_ready[k] <= 1'b0;
                        slv_cnt[k]   <= 0;
                        if (bus.PWRITE) slv_mem[k][bus.PADDR[5:2]] <= bus.PWDATA;
                    end else if (slv_cnt[k] >= slv_wait[k]) begin
                        slv_ready[k] <= 1'b1;
                    end else begin
                        slv_cnt[k] <= slv_cnt[k] + 1;
                    end
                end else begin
                    slv_ready[k] <= 1'b0;
                    slv_cnt[k]   <= 0;
                end
            end
        end
    end

    // Slave read data, combinational from the addressed word.
    always_comb begin
        bus.PRDATA_all = '0;
        for (int k = 0; k < NS; k++) begin
            bus.PRDATA_all[32*k +: 32] = (slv_mode[k] == 2) ? 32'hFFFF_FFFF : slv_mem[k][bus.PADDR[5:2]];
        end
    end
    assign bus.PREADY_all = slv_ready;

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] ref_mem[NS][16];
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata  = '0;
    bit          rdata_known = 1'b1;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] init_word(input int k, input int w);
        return 32'h5A00_0000 | 32'(k << 8) | 32'(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU request with full protocol checking. Expected values come from
    // the address map, the wait count and the timeout limit.
    task automatic run_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd, input int w);
        bit            hit, tmo, chk_rd, got;
        int            k, word, access, exp_n, n, psel_n, pen_n, bad, unstable;
        logic [NS-1:0] oh;
        logic [31:0]   rd_obs, a0, d0, exp_rd;
        logic          w0, err_obs;
        hit    = (a >= BASE) && (a < BASE + 32'(NS * WIN));
        k      = hit ? int'((a - BASE) / WIN) : 0;
        word   = int'(a[5:2]);
        access = (2 + w > TO) ? TO : 2 + w;
        tmo    = hit && (2 + w > TO);
        exp_n  = hit ? 2 + access : 2;
        oh     = hit ? NS'(1 << k) : '0;
        chk_rd = 1'b0;
        exp_rd = '0;
        if (hit && tmo) begin
            chk_rd = 1'b1;
            exp_rd = '0;
        end else if (hit && !wr) begin
            chk_rd = 1'b1;
            exp_rd = ref_mem[k][word];
        end else if (hit && wr && rdata_known) begin
            chk_rd = 1'b1;
            exp_rd = last_rdata;
        end
        if (chk_rd) exp_q.push_back(exp_rd);
        if (hit) slv_wait[k] = w;

        @(negedge PCLK);
        bus.transfer = 1'b1;
        bus.addr     = a;
        bus.write    = wr;
        bus.wdata    = wd;
        n = 0; got = 1'b0; psel_n = 0; pen_n = 0; bad = 0; unstable = 0;
        a0 = '0; d0 = '0; w0 = 1'b0; rd_obs = '0; err_obs = 1'b0;
        while (!got && n < 40) begin
            @(negedge PCLK);
            n++;
            if (n == 1) begin
                bus.transfer = 1'b0;
                a0 = bus.PADDR;
                w0 = bus.PWRITE;
                d0 = bus.PWDATA;
            end else if (bus.PADDR !== a0 || bus.PWRITE !== w0 || bus.PWDATA !== d0) begin
                unstable++;
            end
            if (bus.PSEL != '0) begin
                psel_n++;
                if (bus.PSEL !== oh) bad++;
            end
            if (bus.PENABLE) pen_n++;
            if (bus.ready) begin
                got     = 1'b1;
                rd_obs  = bus.rdata;
                err_obs = bus.err;
            end
        end

        if (!hit) rdata_known = 1'b0;
        else if (tmo) begin
            last_rdata  = '0;
            rdata_known = 1'b1;
        end else if (wr) ref_mem[k][word] = wd;
        else begin
            last_rdata  = ref_mem[k][word];
            rdata_known = 1'b1;
        end

        check("done", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(exp_n));
        check("err", 32'(err_obs), 32'(!hit || tmo));
        if (chk_rd) check("rdata", rd_obs, exp_q.pop_front());
        check("psel_cycles", 32'(psel_n), 32'(hit ? 1 + access : 0));
        check("penable_cycles", 32'(pen_n), 32'(hit ? access : 0));
        check("psel_onehot", 32'(bad), 32'd0);
        check("paddr", a0, a);
        check("pwrite", 32'(w0), 32'(wr));
        check("pwdata", d0, wd);
        check("bus_hold", 32'(unstable), 32'd0);
        @(negedge PCLK);
        check("ready_pulse", {30'd0, bus.ready, bus.err}, 32'd0);
        check("psel_idle", 32'({bus.PSEL, bus.PENABLE}), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int          setups, readys, setup2_at, ready1_at, ready2_at, errs;
        logic [31:0] rd2;
        logic [31:0] a;
        int          sel;
        bus.transfer = 1'b0;
        bus.addr     = '0;
        bus.write    = 1'b0;
        bus.wdata    = '0;
        for (int k = 0; k < NS; k++) begin
            slv_mode[k] = 0;
            slv_wait[k] = 0;
            for (int w = 0; w < 16; w++) begin
                slv_mem[k][w] <= init_word(k, w);
                ref_mem[k][w] = init_word(k, w);
            end
        end

        // Reset state
        #1 PRESET = 1'b1;
        #2;
        check("rst_psel", 32'(bus.PSEL), 32'd0);
        check("rst_penable", 32'(bus.PENABLE), 32'd0);
        check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        check("rst_ready_err", {30'd0, bus.ready, bus.err}, 32'd0);
        check("rst_paddr", bus.PADDR, 32'd0);
        check("rst_pwdata", bus.PWDATA, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Write to slave 1 with a registered PREADY
        run_xfer(32'h1000_1004, 1'b1, 32'h0000_00FF, 0);

        // Read slave 0 while slave 2 holds PREADY high with all-ones data
        slv_mem[0][2] <= 32'h0000_A5A5;
        ref_mem[0][2] = 32'h0000_A5A5;
        slv_mode[2]   = 2;
        run_xfer(32'h1000_0008, 1'b0, 32'h0, 0);
        slv_mode[2]   = 0;

        // Decode misses: outside the region and slave index beyond the last slave
        run_xfer(32'h2000_0000, 1'b0, 32'h0, 0);
        run_xfer(32'h1000_3000, 1'b0, 32'h0, 0);
        run_xfer(32'h1000_4000, 1'b1, 32'h1234_5678, 0);

        // Timeout with PREADY stuck low
        slv_mode[1] = 1;
        run_xfer(32'h1000_1010, 1'b0, 32'h0, 100);
        slv_mode[1] = 0;

        // PREADY on the edge where the count expires: success wins
        run_xfer(32'h1000_2004, 1'b0, 32'h0, TO - 2);
        // One more wait cycle: timeout
        run_xfer(32'h1000_2008, 1'b0, 32'h0, TO - 1);

        // Asynchronous reset in the middle of ACCESS
        slv_wait[1] = 5;
        @(negedge PCLK);
        bus.transfer = 1'b1;
        bus.addr     = 32'h1000_1020;
        bus.write    = 1'b1;
        bus.wdata    = 32'hDEAD_BEEF;
        @(negedge PCLK);
        bus.transfer = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("pre_reset_penable", 32'(bus.PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        check("mid_rst_psel", 32'(bus.PSEL), 32'd0);
        check("mid_rst_penable", 32'(bus.PENABLE), 32'd0);
        check("mid_rst_ready_err", {30'd0, bus.ready, bus.err}, 32'd0);
        check("mid_rst_paddr", bus.PADDR, 32'd0);
        check("mid_rst_rdata", bus.rdata, 32'd0);
        @(negedge PCLK);
        PRESET      = 1'b0;
        last_rdata  = '0;
        rdata_known = 1'b1;
        run_xfer(32'h1000_1020, 1'b1, 32'h0BAD_F00D, 1);
        run_xfer(32'h1000_1020, 1'b0, 32'h0, 2);

        // transfer held high across two requests: write then read of the same word
        slv_wait[2] = 1;
        setups = 0; readys = 0; setup2_at = 0; ready1_at = 0; ready2_at = 0; errs = 0; rd2 = '0;
        @(negedge PCLK);
        bus.transfer = 1'b1;
        bus.addr     = 32'h1000_2020;
        bus.write    = 1'b1;
        bus.wdata    = 32'hCAFE_0006;
        for (int c = 1; c <= 16; c++) begin
            @(negedge PCLK);
            if (bus.PSEL != '0 && !bus.PENABLE) begin
                setups++;
                if (setups == 2) setup2_at = c;
            end
            if (bus.ready) begin
                readys++;
                if (bus.err) errs++;
                if (readys == 1) begin
                    ready1_at = c;
                    bus.addr  = 32'h1000_2020;
                    bus.write = 1'b0;
                end else begin
                    ready2_at = c;
                    rd2       = bus.rdata;
                end
            end
            if (c == 10) bus.transfer = 1'b0;
        end
        ref_mem[2][8] = 32'hCAFE_0006;
        last_rdata    = 32'hCAFE_0006;
        rdata_known   = 1'b1;
        check("b2b_setups", 32'(setups), 32'd2);
        check("b2b_readys", 32'(readys), 32'd2);
        check("b2b_first_ready", 32'(ready1_at), 32'd5);
        check("b2b_second_setup", 32'(setup2_at), 32'(ready1_at + 1));
        check("b2b_second_ready", 32'(ready2_at), 32'd10);
        check("b2b_errs", 32'(errs), 32'd0);
        check("b2b_rdata", rd2, 32'hCAFE_0006);

        // Randomized transfers: hits on every slave, misses, waits up to timeout
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 5);
            if (sel <= 2) a = BASE + 32'(sel * WIN) + 32'($urandom_range(0, 15) * 4);
            else if (sel == 3) a = 32'h1000_3000 + 32'($urandom_range(0, 1023) * 4);
            else if (sel == 4) a = 32'h2000_0000 + 32'($urandom_range(0, 255) * 4);
            else a = ($urandom_range(0, 1) == 1) ? 32'h1000_4000 : 32'h0FFF_FFFC;
            run_xfer(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TO));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
